cl_frame_gen: RTL and testbench
===============================

Name: cl_frame_gen

Overview:
- Camera Link base-configuration camera emulator. Sits directly upstream of the cl receiver.
- Generates FVAL/LVAL framing and 8-bit pixel data on ports A/B/C, with programmable line and frame timing and selectable test patterns.
- Used in benches and on-board loopback to exercise the receiver without a physical camera.

Parameters:
- H_ACTIVE, 640, pixel clocks with LVAL high per line (>=1)
- H_BLANK, 16, LVAL-low clocks between consecutive lines within a frame (>=1)
- V_ACTIVE, 480, lines per frame (>=1)
- FV_SETUP, 4, clocks from FVAL rise to first LVAL rise (>=1)
- V_BLANK, 64, FVAL-low clocks between frames (>=1)
- CW, 16, width of internal x/y/phase counters (must hold every parameter value)

Ports:
- cl_x_pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; high requests continuous frame generation
- pattern_sel  in  2  00 ramp, 01 fixed, 10 checker, 11 ramp
- cl_fval  out  1  frame valid
- cl_lval  out  1  line valid
- cl_port_a  out  8  pixel byte A
- cl_port_b  out  8  pixel byte B
- cl_port_c  out  8  pixel byte C
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. Reset (async assert) forces: state IDLE, cl_fval=0, cl_lval=0, ports=0, frame_count=0, busy=0, all counters=0.
- Release of reset is synchronous to cl_x_pclk.
- States: IDLE, SETUP, LINE, HBLANK, VBLANK.
- IDLE: outputs low.
  - enable=1 sampled -> SETUP on next edge.
  - pattern_sel is latched at every entry into SETUP and held for the whole frame.
- SETUP: fval=1, lval=0 for exactly FV_SETUP clocks -> LINE. y=0.
- LINE: fval=1, lval=1 for exactly H_ACTIVE clocks.
  - x counts 0..H_ACTIVE-1.
  - After the last pixel: if y<V_ACTIVE-1 -> HBLANK; else -> VBLANK.
- HBLANK: fval=1, lval=0 for exactly H_BLANK clocks. Then y increments and state -> LINE with x=0.
- VBLANK: fval=0, lval=0 for exactly V_BLANK clocks.
  - frame_count increments on the edge entering VBLANK.
  - At the end of VBLANK: enable=1 -> SETUP; enable=0 -> IDLE.
- Frame length with fval high = FV_SETUP + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK clocks.
- Frame period = that value + V_BLANK clocks.
- enable dropped mid-frame: the current frame and its VBLANK complete normally, then the block goes to IDLE. No truncated frames.
- Data when lval=1 (latched pattern):
  - ramp: a=x[7:0], b=y[7:0], c=frame_count[7:0].
  - fixed: a=8'hA5, b=8'h5A, c=8'hFF.
  - checker: a=b=c = (x[0]^y[0]) ? 8'hFF : 8'h00.
- Data when lval=0: all ports = 8'h00.
- Data is aligned with lval in the same cycle.
- x/y wrap naturally modulo 256 in the ramp bytes. Counters themselves never exceed their parameter limits.
- Async reset mid-frame: outputs drop immediately. Restart requires enable after release; the first frame after reset starts with SETUP.

Decomposition:
- Shared package cl_pkg holds:
  - state enum (IDLE/SETUP/LINE/HBLANK/VBLANK)
  - pattern_sel encodings
  - constants PAT_FIXED_A=8'hA5, PAT_FIXED_B=8'h5A, PAT_FIXED_C=8'hFF
- Sub-module cl_pattern: combinational pattern mux taking x, y, frame_count and pattern, registered in the parent. Everything else (FSM and counters) stays in cl_frame_gen.

Test Plan:
Bench parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, FV_SETUP=2, V_BLANK=5.
- Reset: assert reset mid-LINE -> fval, lval, ports and frame_count go to 0 without waiting for a clock edge; busy=0.
- Single frame, ramp: enable pulse high for 1 clk then low.
  - fval high 18 clks, SETUP 2 clks, three LVAL bursts of 4 clks separated by 2 clks.
  - Port A is 0,1,2,3 on each line; port B is 0, 1, 2 per line; port C=0.
  - Then 5 clks VBLANK, frame_count=1, return to IDLE.
- Continuous: enable held high for 3 frames -> period is exactly 23 clks; frame_count 1, 2, 3; port C is 0, 1, 2 on the respective frames.
- Fixed pattern: pattern_sel=01 -> every LVAL-high cycle has A=A5, B=5A, C=FF; all ports are 00 whenever lval=0.
- Pattern latch: change pattern_sel from 00 to 10 mid-frame -> current frame stays ramp; the next frame is checker (line 0: 00,FF,00,FF; line 1: FF,00,FF,00).
- Enable drop mid-frame: deassert during line 1 -> frame completes all 3 lines plus VBLANK, frame_count increments, then IDLE with busy=0.

Source files
------------

// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link frame generator.
// Holds the FSM state encoding, pattern_sel encodings and fixed-pattern bytes.
package cl_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } state_t;

  localparam logic [1:0] PAT_RAMP     = 2'b00;
  localparam logic [1:0] PAT_FIXED    = 2'b01;
  localparam logic [1:0] PAT_CHECKER  = 2'b10;
  localparam logic [1:0] PAT_RAMP_ALT = 2'b11;

  localparam logic [PIX_W-1:0] PAT_FIXED_A = 8'hA5;
  localparam logic [PIX_W-1:0] PAT_FIXED_B = 8'h5A;
  localparam logic [PIX_W-1:0] PAT_FIXED_C = 8'hFF;

endpackage

// File: rtl/cl_pattern.sv
// Combinational test-pattern mux; the parent registers the result.
// Ports:
//   x, y     : pixel / line position (low byte)
//   fcount   : completed-frame count (low byte)
//   pattern  : latched pattern select
//   a_c/b_c/c_c : pixel bytes for ports A/B/C
module cl_pattern
  import cl_pkg::*;
(
  input  logic [PIX_W-1:0] x,
  input  logic [PIX_W-1:0] y,
  input  logic [PIX_W-1:0] fcount,
  input  logic [1:0]       pattern,
  output logic [PIX_W-1:0] a_c,
  output logic [PIX_W-1:0] b_c,
  output logic [PIX_W-1:0] c_c
);

  logic chk;

  always_comb begin
    chk = x[0] ^ y[0];
    a_c = x;
    b_c = y;
    c_c = fcount;
    case (pattern)
      PAT_FIXED: begin
        a_c = PAT_FIXED_A;
        b_c = PAT_FIXED_B;
        c_c = PAT_FIXED_C;
      end
      PAT_CHECKER: begin
        a_c = {PIX_W{chk}};
        b_c = {PIX_W{chk}};
        c_c = {PIX_W{chk}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cl_frame_gen.sv
// Camera Link base-configuration camera emulator.
// Ports:
//   cl_x_pclk   : pixel clock, rising edge
//   reset       : asynchronous active-high reset
//   enable      : level request for continuous frame generation
//   pattern_sel : 00/11 ramp, 01 fixed, 10 checker (latched on entry to SETUP)
//   cl_fval/cl_lval : frame / line valid
//   cl_port_a/b/c   : pixel bytes, zero whenever cl_lval is low
//   frame_count : completed frames, wraps
//   busy        : high whenever not idle
module cl_frame_gen
  import cl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned FV_SETUP = 4,
  parameter int unsigned V_BLANK  = 64,
  parameter int unsigned CW       = 16
) (
  input  logic             cl_x_pclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  output logic             cl_fval,
  output logic             cl_lval,
  output logic [PIX_W-1:0] cl_port_a,
  output logic [PIX_W-1:0] cl_port_b,
  output logic [PIX_W-1:0] cl_port_c,
  output logic [15:0]      frame_count,
  output logic             busy
);

  localparam int unsigned FC_W = 16;

  state_t          state_q, state_d;
  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;
  logic [CW-1:0]   phase_q, phase_d;
  logic [FC_W-1:0] fc_d;
  logic [1:0]      pat_q, pat_d;
  logic            fval_d, lval_d;
  logic [PIX_W-1:0] pa_c, pb_c, pc_c;

  // Next-state and counter logic; outputs are derived from the next state so
  // the registered outputs line up with the registered state.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    fc_d    = frame_count;
    pat_d   = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SETUP;
          pat_d   = pattern_sel;
          phase_d = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_SETUP: begin
        if (phase_q == CW'(FV_SETUP - 1)) begin
          state_d = ST_LINE;
          phase_d = '0;
          x_d     = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      ST_LINE: begin
        if (x_q == CW'(H_ACTIVE - 1)) begin
          x_d     = '0;
          phase_d = '0;
          if (y_q < CW'(V_ACTIVE - 1)) begin
            state_d = ST_HBLANK;
          end else begin
            state_d = ST_VBLANK;
            fc_d    = frame_count + FC_W'(1);
          end
        end else begin
          x_d = x_q + CW'(1);
        end
      end
      ST_HBLANK: begin
        if (phase_q == CW'(H_BLANK - 1)) begin
          state_d = ST_LINE;
          phase_d = '0;
          x_d     = '0;
          y_d     = y_q + CW'(1);
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      ST_VBLANK: begin
        if (phase_q == CW'(V_BLANK - 1)) begin
          phase_d = '0;
          y_d     = '0;
          if (enable) begin
            state_d = ST_SETUP;
            pat_d   = pattern_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fval_d = (state_d == ST_SETUP) || (state_d == ST_LINE) || (state_d == ST_HBLANK);
    lval_d = (state_d == ST_LINE);
  end

  cl_pattern u_pattern (
    .x       (x_d[PIX_W-1:0]),
    .y       (y_d[PIX_W-1:0]),
    .fcount  (fc_d[PIX_W-1:0]),
    .pattern (pat_d),
    .a_c     (pa_c),
    .b_c     (pb_c),
    .c_c     (pc_c)
  );

  // State, counters and registered outputs.
  always_ff @(posedge cl_x_pclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= '0;
      pat_q       <= PAT_RAMP;
      frame_count <= '0;
      cl_fval     <= 1'b0;
      cl_lval     <= 1'b0;
      cl_port_a   <= '0;
      cl_port_b   <= '0;
      cl_port_c   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      pat_q       <= pat_d;
      frame_count <= fc_d;
      cl_fval     <= fval_d;
      cl_lval     <= lval_d;
      cl_port_a   <= lval_d ? pa_c : '0;
      cl_port_b   <= lval_d ? pb_c : '0;
      cl_port_c   <= lval_d ? pc_c : '0;
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cl_frame_gen.sv
// Directed bench for cl_frame_gen with a small per-cycle frame model.
module tb_cl_frame_gen;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int FS = 2;
  localparam int VB = 5;
  localparam int FLEN = FS + VA * HA + (VA - 1) * HB;  // 18
  localparam int PER  = FLEN + VB;                     // 23

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        cl_fval, cl_lval, busy;
  logic [7:0]  cl_port_a, cl_port_b, cl_port_c;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  cl_frame_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .FV_SETUP(FS), .V_BLANK(VB), .CW(16)
  ) dut (
    .cl_x_pclk  (clk),
    .reset      (reset),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .cl_fval    (cl_fval),
    .cl_lval    (cl_lval),
    .cl_port_a  (cl_port_a),
    .cl_port_b  (cl_port_b),
    .cl_port_c  (cl_port_c),
    .frame_count(frame_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected {fval, lval, busy, a, b, c, frame_count} at cycle k of a frame
  // (k=0 is the first SETUP cycle); fc_pre is frame_count before this frame.
  function automatic logic [42:0] exp_cycle(input int k, input logic [1:0] pat, input int fc_pre);
    logic fv, lv, bz;
    logic [7:0] a, b, c, xv, yv;
    logic [15:0] fc;
    int r, ln, pos;
    fv = 1'b0; lv = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
    if (k < FS) begin
      fv = 1'b1;
    end else if (k < FLEN) begin
      fv  = 1'b1;
      r   = k - FS;
      ln  = r / (HA + HB);
      pos = r % (HA + HB);
      if (pos < HA) begin
        lv = 1'b1;
        xv = 8'(pos);
        yv = 8'(ln);
        if (pat == 2'b01) begin
          a = 8'hA5; b = 8'h5A; c = 8'hFF;
        end else if (pat == 2'b10) begin
          a = ((pos + ln) % 2 == 1) ? 8'hFF : 8'h00;
          b = a; c = a;
        end else begin
          a = xv; b = yv; c = 8'(fc_pre);
        end
      end
    end
    fc = 16'(fc_pre + ((k >= FLEN) ? 1 : 0));
    bz = (k < PER);
    return {fv, lv, bz, a, b, c, fc};
  endfunction

  function automatic logic [42:0] obs();
    return {cl_fval, cl_lval, busy, cl_port_a, cl_port_b, cl_port_c, frame_count};
  endfunction

  task automatic apply_reset;
    enable = 1'b0;
    reset  = 1'b1;
    step;
    step;
    reset = 1'b0;
    step;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; pattern_sel = 2'b00;
    #1;
    checks++;
    if (obs() !== 43'd0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", obs(), 43'd0);
    end
    step;
    reset = 1'b0;
    step;
    checks++;
    if (obs() !== 43'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", obs(), 43'd0);
    end
  endtask

  task automatic test_single_ramp;
    logic [42:0] e;
    apply_reset;
    pattern_sel = 2'b00;
    enable = 1'b1;
    step;
    enable = 1'b0;
    for (int k = 0; k <= PER; k++) begin
      e = exp_cycle(k, 2'b00, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL single_ramp k=%0d: got %h expected %h", k, obs(), e);
      end
      step;
    end
  endtask

  task automatic test_continuous;
    logic [42:0] e;
    logic prev;
    int rises[$];
    int g;
    apply_reset;
    pattern_sel = 2'b00;
    enable = 1'b1;
    prev = 1'b0;
    g = 0;
    step;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < PER; k++) begin
        e = exp_cycle(k, 2'b00, f);
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL continuous f=%0d k=%0d: got %h expected %h", f, k, obs(), e);
        end
        if (cl_fval && !prev) rises.push_back(g);
        prev = cl_fval;
        if (f == 2 && k == FLEN) enable = 1'b0;
        g++;
        step;
      end
    end
    e = exp_cycle(PER, 2'b00, 2);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL continuous_idle: got %h expected %h", obs(), e);
    end
    checks++;
    if (rises.size() != 3) begin
      errors++;
      $display("FAIL continuous_rises: got %0d expected %0d", rises.size(), 3);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rises[i] - rises[i-1] != PER) begin
          errors++;
          $display("FAIL continuous_period%0d: got %0d expected %0d", i, rises[i] - rises[i-1], PER);
        end
      end
    end
  endtask

  task automatic test_fixed;
    logic [42:0] e;
    apply_reset;
    pattern_sel = 2'b01;
    enable = 1'b1;
    step;
    enable = 1'b0;
    for (int k = 0; k <= PER; k++) begin
      e = exp_cycle(k, 2'b01, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL fixed k=%0d: got %h expected %h", k, obs(), e);
      end
      step;
    end
  endtask

  task automatic test_pattern_latch;
    logic [42:0] e;
    apply_reset;
    pattern_sel = 2'b00;
    enable = 1'b1;
    step;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < PER; k++) begin
        e = exp_cycle(k, (f == 0) ? 2'b00 : 2'b10, f);
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL pattern_latch f=%0d k=%0d: got %h expected %h", f, k, obs(), e);
        end
        if (f == 0 && k == 9) pattern_sel = 2'b10;
        if (f == 1 && k == FLEN) enable = 1'b0;
        step;
      end
    end
    e = exp_cycle(PER, 2'b10, 1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL pattern_latch_idle: got %h expected %h", obs(), e);
    end
    pattern_sel = 2'b00;
  endtask

  task automatic test_enable_drop;
    logic [42:0] e;
    apply_reset;
    pattern_sel = 2'b00;
    enable = 1'b1;
    step;
    for (int k = 0; k <= PER + 2; k++) begin
      e = exp_cycle((k > PER) ? PER : k, 2'b00, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL enable_drop k=%0d: got %h expected %h", k, obs(), e);
      end
      if (k == 9) enable = 1'b0;
      step;
    end
  endtask

  task automatic test_reset_mid_line;
    logic [42:0] e;
    // frame_count is 1 from the previous test
    pattern_sel = 2'b00;
    enable = 1'b1;
    step;
    enable = 1'b0;
    step; step; step;
    checks++;
    if (cl_lval !== 1'b1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_mid_pre: got lval=%b fc=%0d expected lval=1 fc=1", cl_lval, frame_count);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 43'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", obs(), 43'd0);
    end
    step;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (obs() !== 43'd0) begin
        errors++;
        $display("FAIL reset_mid_idle%0d: got %h expected %h", i, obs(), 43'd0);
      end
    end
    enable = 1'b1;
    step;
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      e = exp_cycle(k, 2'b00, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_restart k=%0d: got %h expected %h", k, obs(), e);
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_single_ramp;
    test_continuous;
    test_fixed;
    test_pattern_latch;
    test_enable_drop;
    test_reset_mid_line;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
